// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with a small transmit FIFO.
// Pushes are taken on the rising edge of begin_flag; frames are start, data (LSB first), parity, stop.
module uart_tx_cfg #(
  parameter int unsigned CLOCK_HZ   = 50_000_000,
  parameter int unsigned BAUD_RATE  = 115200,
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned PARITY     = 0,
  parameter int unsigned STOP_BITS  = 1,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 begin_flag,
  input  logic [DATA_BITS-1:0] data,
  output logic                 tx,
  output logic                 busy_flag,
  output logic                 full,
  output logic                 overflow
);

  localparam int unsigned CLKS_PER_BIT = CLOCK_HZ / BAUD_RATE;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BW = $clog2(DATA_BITS + 1);

  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  logic                 begin_q;
  logic                 push;
  logic                 pop;
  logic                 wr_en;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [DATA_BITS-1:0] head;
  logic [AW-1:0]        wr_ptr_q;
  logic [AW-1:0]        rd_ptr_q;
  logic [AW:0]          count_q, count_d;

  logic [2:0]           state_q, state_d;
  logic [CW-1:0]        baud_q, baud_d;
  logic [BW-1:0]        bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_q, par_d;
  logic                 bit_end;
  logic                 line;

  logic                 tx_q;
  logic                 busy_q;
  logic                 full_q;
  logic                 overflow_q;

  assign push       = begin_flag & ~begin_q;
  assign fifo_full  = (count_q == FULL_CNT);
  assign fifo_empty = (count_q == '0);
  assign pop        = (state_q == ST_IDLE) && !fifo_empty;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en      = push && (!fifo_full || pop);
  assign head       = mem[rd_ptr_q];
  assign bit_end    = (baud_q == BAUD_LAST);

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    state_d = state_q;
    baud_d  = bit_end ? '0 : baud_q + 1'b1;
    bit_d   = bit_q;
    shift_d = shift_q;
    par_d   = par_q;
    line    = 1'b1;
    case (state_q)
      ST_IDLE: begin
        baud_d = '0;
        bit_d  = '0;
        if (pop) begin
          shift_d = head;
          par_d   = (PARITY == 1) ? ~(^head) : ^head;
          state_d = ST_START;
        end
      end
      ST_START: begin
        line = 1'b0;
        if (bit_end) state_d = ST_DATA;
      end
      ST_DATA: begin
        line = shift_q[0];
        if (bit_end) begin
          shift_d = shift_q >> 1;
          if (bit_q == DATA_LAST) begin
            bit_d   = '0;
            state_d = (PARITY != 0) ? ST_PARITY : ST_STOP;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      ST_PARITY: begin
        line = par_q;
        if (bit_end) state_d = ST_STOP;
      end
      ST_STOP: begin
        line = 1'b1;
        if (bit_end) begin
          if (bit_q == STOP_LAST) begin
            bit_d   = '0;
            state_d = ST_IDLE;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        baud_d  = '0;
        bit_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en && !rst) mem[wr_ptr_q] <= data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      begin_q    <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      state_q    <= ST_IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      shift_q    <= '0;
      par_q      <= 1'b0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      full_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      begin_q    <= begin_flag;
      if (wr_en) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)   rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q    <= count_d;
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      par_q      <= par_d;
      // tx trails the state by one cycle, giving the 2-cycle push-to-start latency.
      tx_q       <= line;
      busy_q     <= !((state_d == ST_IDLE) && (count_d == '0));
      full_q     <= (count_d == FULL_CNT);
      overflow_q <= push && fifo_full && !pop;
    end
  end

  assign tx        = tx_q;
  assign busy_flag = busy_q;
  assign full      = full_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Bench for uart_tx_cfg: four configurations driven together, checked each cycle against a
// frame-level model, plus literal waveform expectations.
module tb_uart_tx_cfg;

  localparam int CPB   = 434;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       b   = 1'b0;
  logic [7:0] d0 = '0, d1 = '0, d2 = '0;
  logic [6:0] d3 = '0;
  logic [3:0] tx_w, busy_w, full_w, ovf_w;

  int cyc = 0;
  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx_cfg u0 (
    .clk(clk), .rst(rst), .begin_flag(b), .data(d0),
    .tx(tx_w[0]), .busy_flag(busy_w[0]), .full(full_w[0]), .overflow(ovf_w[0])
  );
  uart_tx_cfg #(.PARITY(2)) u1 (
    .clk(clk), .rst(rst), .begin_flag(b), .data(d1),
    .tx(tx_w[1]), .busy_flag(busy_w[1]), .full(full_w[1]), .overflow(ovf_w[1])
  );
  uart_tx_cfg #(.PARITY(1)) u2 (
    .clk(clk), .rst(rst), .begin_flag(b), .data(d2),
    .tx(tx_w[2]), .busy_flag(busy_w[2]), .full(full_w[2]), .overflow(ovf_w[2])
  );
  uart_tx_cfg #(.DATA_BITS(7), .STOP_BITS(2)) u3 (
    .clk(clk), .rst(rst), .begin_flag(b), .data(d3),
    .tx(tx_w[3]), .busy_flag(busy_w[3]), .full(full_w[3]), .overflow(ovf_w[3])
  );

  function automatic int db_of(input int i);
    return (i == 3) ? 7 : 8;
  endfunction
  function automatic int par_of(input int i);
    return (i == 1) ? 2 : ((i == 2) ? 1 : 0);
  endfunction
  function automatic int sb_of(input int i);
    return (i == 3) ? 2 : 1;
  endfunction
  function automatic int flen_of(input int i);
    return 1 + db_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i);
  endfunction
  function automatic int wdata(input int i);
    case (i)
      0: return int'(d0);
      1: return int'(d1);
      2: return int'(d2);
      default: return int'(d3);
    endcase
  endfunction

  // Line bits of one frame, index 0 = start bit; every bit past the payload is a stop bit.
  function automatic logic [15:0] mk_frame(input int i, input int w);
    logic [15:0] f;
    logic        p;
    f    = '1;
    f[0] = 1'b0;
    p    = 1'b0;
    for (int k = 0; k < db_of(i); k++) begin
      f[1+k] = w[k];
      p      = p ^ w[k];
    end
    if (par_of(i) != 0) f[1+db_of(i)] = (par_of(i) == 1) ? ~p : p;
    return f;
  endfunction

  int          mq [4][8];
  int          mn [4];
  int          ft [4];
  logic [15:0] fb [4];
  int          fl [4];
  logic        mprev [4];
  logic [3:0]  e_tx, e_busy, e_full, e_ovf;

  // ft is the cycle offset into the frame in flight (-1 when the line is idle).
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst) begin
        mn[i] = 0; ft[i] = -1; mprev[i] = 1'b1;
        e_tx[i] = 1'b1; e_busy[i] = 1'b0; e_full[i] = 1'b0; e_ovf[i] = 1'b0;
      end else begin
        logic pushm, popm, fullpre;
        pushm    = b && !mprev[i];
        mprev[i] = b;
        e_tx[i]  = (ft[i] >= 0) ? fb[i][ft[i] / CPB] : 1'b1;
        fullpre  = (mn[i] == DEPTH);
        popm     = 1'b0;
        if (ft[i] >= 0) begin
          ft[i] = ft[i] + 1;
          if (ft[i] == fl[i] * CPB) ft[i] = -1;
        end else if (mn[i] > 0) begin
          popm  = 1'b1;
          fb[i] = mk_frame(i, mq[i][0]);
          fl[i] = flen_of(i);
          for (int k = 0; k < 7; k++) mq[i][k] = mq[i][k+1];
          mn[i] = mn[i] - 1;
          ft[i] = 0;
        end
        if (pushm && (!fullpre || popm)) begin
          mq[i][mn[i]] = wdata(i);
          mn[i] = mn[i] + 1;
        end
        e_ovf[i]  = pushm && fullpre && !popm;
        e_full[i] = (mn[i] == DEPTH);
        e_busy[i] = !((ft[i] < 0) && (mn[i] == 0));
      end
    end
  end

  task automatic finish_run();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) begin
      passes++;
    end else begin
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
      if (checks - passes >= 40) finish_run();
    end
  endtask

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      check($sformatf("inst%0d {tx,busy,full,ovf}", i),
            int'({tx_w[i], busy_w[i], full_w[i], ovf_w[i]}),
            int'({e_tx[i], e_busy[i], e_full[i], e_ovf[i]}));
    end
  end

  task automatic tick_to(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    logic [9:0] bits_a, bits_d;
    logic [7:0] words [6];
    int p, p1, p2, r0, c1, c2, f2;
    bits_a = 10'b1101010100;
    bits_d = 10'b1110101010;
    words[0] = 8'h3C; words[1] = 8'hC5; words[2] = 8'h0F;
    words[3] = 8'h81; words[4] = 8'h7E; words[5] = 8'h99;

    // Reset state
    tick_to(2);
    check("rst_tx", tx_w[0], 1);
    check("rst_busy", busy_w[0], 0);
    check("rst_full", full_w[0], 0);
    check("rst_ovf", ovf_w[0], 0);
    tick_to(5);
    rst = 1'b0;

    // Single frame on all configurations, begin_flag held high for several cycles
    tick_to(10);
    check("A_busy_before", busy_w[0], 0);
    d0 = 8'hAA; d1 = 8'hAA; d2 = 8'hAA; d3 = 7'h55;
    b  = 1'b1;
    p  = 11;
    tick_to(p);
    check("A_busy_rise", busy_w[0], 1);
    tick_to(p + 1);
    check("A_tx_still_high", tx_w[0], 1);
    tick_to(p + 2);
    check("A_tx_start", tx_w[0], 0);
    tick_to(p + 4);
    b = 1'b0;
    d0 = 8'h00; d1 = 8'hFF; d2 = 8'h00; d3 = 7'h7F;
    for (int k = 0; k < 10; k++) begin
      tick_to(p + 2 + k * CPB + CPB / 2);
      check($sformatf("A_u0_bit%0d", k), tx_w[0], bits_a[k]);
      check($sformatf("A_u3_bit%0d", k), tx_w[3], bits_d[k]);
      if (k == 9) begin
        check("A_even_parity", tx_w[1], 0);
        check("A_odd_parity", tx_w[2], 1);
      end
    end
    tick_to(p + 10 * CPB);
    check("A_u0_busy_last", busy_w[0], 1);
    check("A_u3_busy_last", busy_w[3], 1);
    tick_to(p + 10 * CPB + 1);
    check("A_u0_busy_drop", busy_w[0], 0);
    check("A_u3_busy_drop", busy_w[3], 0);
    tick_to(p + 2 + 10 * CPB + CPB / 2);
    check("A_u1_stop", tx_w[1], 1);
    tick_to(p + 11 * CPB);
    check("A_u1_busy_last", busy_w[1], 1);
    tick_to(p + 11 * CPB + 1);
    check("A_u1_busy_drop", busy_w[1], 0);
    tick_to(p + 4800);

    // Burst of six pushes while the first frame is sending
    c1 = cyc;
    p1 = c1 + 1;
    for (int j = 0; j < 6; j++) begin
      tick_to(c1 + 2 * j);
      if (j == 4) check("B_not_full", full_w[0], 0);
      d0 = words[j]; d1 = words[j]; d2 = words[j]; d3 = words[j][6:0];
      b  = 1'b1;
      tick_to(c1 + 2 * j + 1);
      b  = 1'b0;
      if (j == 4) check("B_full", full_w[0], 1);
      if (j == 5) begin
        check("B_ovf_pulse", ovf_w[0], 1);
        check("B_full_held", full_w[0], 1);
      end
    end
    tick_to(c1 + 12);
    check("B_ovf_clear", ovf_w[0], 0);
    f2 = p1 + 2 + 10 * CPB + 1;
    tick_to(f2 - 1);
    check("B_gap_idle", tx_w[0], 1);
    tick_to(f2);
    check("B_frame2_start", tx_w[0], 0);
    tick_to(f2 + CPB + CPB / 2);
    check("B_frame2_bit0", tx_w[0], 1);
    tick_to(c1 + 24000);

    // Three queued frames, reset during the second with begin_flag rising inside reset
    c2 = cyc;
    p2 = c2 + 1;
    for (int j = 0; j < 3; j++) begin
      tick_to(c2 + 2 * j);
      d0 = words[j+2]; d1 = words[j+2]; d2 = words[j+2]; d3 = words[j+2][6:0];
      b  = 1'b1;
      tick_to(c2 + 2 * j + 1);
      b  = 1'b0;
    end
    r0 = p2 + 1 + 10 * CPB + 1 + 3 * CPB + 100;
    tick_to(r0);
    check("C_busy_mid", busy_w[0], 1);
    rst = 1'b1;
    b   = 1'b1;
    tick_to(r0 + 1);
    check("C_rst_tx", tx_w[0], 1);
    check("C_rst_busy", busy_w[0], 0);
    tick_to(r0 + 3);
    rst = 1'b0;
    tick_to(r0 + 3000);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("C_inst%0d_tx_idle", i), tx_w[i], 1);
      check($sformatf("C_inst%0d_no_push", i), busy_w[i], 0);
    end
    b = 1'b0;
    tick_to(r0 + 3010);
    finish_run();
  end

endmodule

// File: doc/uart_tx_cfg.md
UART_TX_CFG -- requirements
Module: uart_tx_cfg

Interface
REQ-001 SHALL have parameter CLOCK_HZ, default 50_000_000: clk frequency in Hz.
REQ-002 SHALL have parameter BAUD_RATE, default 115200: line bit rate.
REQ-003 SHALL have parameter DATA_BITS, default 8: data bits per frame; legal range 5..9.
REQ-004 SHALL have parameter PARITY, default 0: 0 none, 1 odd, 2 even.
REQ-005 SHALL have parameter STOP_BITS, default 1: legal values 1 or 2.
REQ-006 SHALL have parameter FIFO_DEPTH, default 4: transmit FIFO entries; power of two, at least 2.
REQ-007 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-008 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-009 SHALL have port begin_flag, input, 1: push request; the rising edge enqueues data.
REQ-010 SHALL have port data, input, DATA_BITS: word sampled on the begin_flag rising-edge cycle.
REQ-011 SHALL have port tx, output, 1: serial line; idles high.
REQ-012 SHALL have port busy_flag, output, 1: high while a frame is on the line or the FIFO is non-empty.
REQ-013 SHALL have port full, output, 1: FIFO holds FIFO_DEPTH entries.
REQ-014 SHALL have port overflow, output, 1: one-cycle pulse when a push is dropped.

Function
REQ-015 SHALL set CLKS_PER_BIT = floor(CLOCK_HZ/BAUD_RATE); every line bit lasts exactly CLKS_PER_BIT clk cycles (434 at defaults).
REQ-016 SHALL detect a push as begin_flag==1 at the current edge and ==0 at the previous edge; a held-high level pushes once only.
REQ-017 SHALL write data into the FIFO on the push cycle when not full; SHALL drop it and pulse overflow for exactly 1 cycle when full with no simultaneous pop.
REQ-018 SHALL accept a push when the FIFO is full and a pop occurs in the same cycle; the occupancy is unchanged.
REQ-019 SHALL wrap the FIFO read and write pointers modulo FIFO_DEPTH; full and empty SHALL derive from an occupancy counter of width log2(FIFO_DEPTH)+1.
REQ-020 SHALL implement FSM states IDLE, START, DATA, PARITY, STOP.
REQ-021 IDLE: tx=1; if the FIFO is non-empty, pop the head into the shift register, go to START.
REQ-022 START: tx=0 for one bit time, then DATA.
REQ-023 DATA: send DATA_BITS bits LSB first; after the last bit go to PARITY if PARITY!=0, else to STOP.
REQ-024 PARITY: drive one bit: even = XOR of the data bits; odd = its inverse.
REQ-025 STOP: drive tx=1 for STOP_BITS bit times, then go to IDLE.
REQ-026 From IDLE, with an empty FIFO and not in reset, tx SHALL fall exactly 2 clk cycles after the cycle on which the push is detected (1 cycle write, 1 cycle pop/IDLE->START).
REQ-027 Back-to-back frames: when the FIFO is non-empty at the end of STOP, the next start bit SHALL follow after exactly 1 IDLE cycle.
REQ-028 busy_flag SHALL be low only when the state is IDLE and the FIFO is empty; it SHALL rise in the cycle after a push is accepted.
REQ-029 Changes on data or begin_flag during a frame SHALL NOT affect the frame in flight.
REQ-030 All outputs SHALL be registered; tx SHALL be glitch-free.

Reset
REQ-031 While rst=1 at a clk edge: tx=1, busy_flag=0, full=0, overflow=0, state=IDLE; the FIFO is emptied; baud, bit and stop counters clear.
REQ-032 Reset mid-frame SHALL abort the frame; tx SHALL be 1 from the first edge with rst=1; no partial frame resumes.
REQ-033 The begin_flag edge-history register SHALL reset to 1, so a begin_flag held high through reset does not push.

Verification
REQ-034 Defaults, push 0xAA -> tx low 2 clks after the push; bits 0,0,1,0,1,0,1,0,1,1 each 434 clks; frame is 4340 clks; busy_flag drops after the stop bit.
REQ-035 PARITY=2, push 0xAA -> parity bit 0; PARITY=1 -> parity bit 1; frame is 11 bit times.
REQ-036 DATA_BITS=7, STOP_BITS=2, push 0x55 -> 7 data bits 1,0,1,0,1,0,1, then 2 stop bits of 868 clks total high before IDLE.
REQ-037 FIFO_DEPTH=4, push 6 words in a burst while the first frame is sending -> words 1-5 are transmitted in order with 1-cycle IDLE gaps; word 6 pulses overflow once; full is asserted while 4 entries are queued.
REQ-038 Assert rst mid-DATA of the second of 3 queued frames -> tx=1 on the next edge; busy_flag=0; no further frames; begin_flag held high across reset produces no push.
